// File: rtl/mem_cache.sv
// Direct-mapped, write-back, write-allocate data cache for 32-bit word requests.
// Misses refill over AXI4 INCR bursts; dirty victims are written back first.
module mem_cache #(
   parameter int LINE_WORDS  = 8,
   parameter int INDEX_WIDTH = 6
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        RECEIVE_ADDR_VALID,
   input  logic [31:0] RECEIVE_ADDR,
   input  logic        RECEIVE_DATA_VALID,
   input  logic [31:0] RECEIVE_DATA,
   output logic        RECEIVE_READY,
   output logic        SEND_VALID,
   output logic [31:0] SEND_DATA,
   input  logic        SEND_READY,
   output logic [31:0] ARADDR,
   output logic        ARVALID,
   input  logic        ARREADY,
   input  logic        RVALID,
   input  logic [31:0] RDATA,
   output logic        RREADY,
   output logic [31:0] AWADDR,
   output logic        AWVALID,
   input  logic        AWREADY,
   output logic [31:0] WDATA,
   output logic        WVALID,
   output logic        WLAST,
   input  logic        WREADY,
   output logic [2:0]  dbg_state
);
   localparam int OFF_W  = $clog2(LINE_WORDS);
   localparam int LINES  = 1 << INDEX_WIDTH;
   localparam int TAG_W  = 30 - OFF_W - INDEX_WIDTH;
   localparam int MEM_AW = INDEX_WIDTH + OFF_W;
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE, LOOKUP, WB_ADDR, WB_DATA, RF_ADDR, RF_DATA, RESP
   } state_t;

   state_t state;

   logic [LINES-1:0]  line_valid;
   logic [LINES-1:0]  line_dirty;
   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [31:0]       data_mem [LINES*LINE_WORDS];

   logic [29:0]       req_word;
   logic [31:0]       req_data;
   logic              req_write;
   logic [OFF_W-1:0]  beat;

   logic [INDEX_WIDTH-1:0] req_index;
   logic [OFF_W-1:0]       req_off;
   logic [TAG_W-1:0]       req_tag;
   logic [OFF_W-1:0]       beat_nxt;
   logic                   hit;
   logic                   mem_we;
   logic [MEM_AW-1:0]      mem_waddr;
   logic [31:0]            mem_wdata;
   logic                   refill_done;

   wire unused_addr_lsb = &{1'b0, RECEIVE_ADDR[1:0]};

   assign req_index   = req_word[OFF_W +: INDEX_WIDTH];
   assign req_off     = req_word[OFF_W-1:0];
   assign req_tag     = req_word[29 -: TAG_W];
   assign beat_nxt    = beat + 1'b1;
   assign hit         = line_valid[req_index] && (tag_mem[req_index] == req_tag);
   assign refill_done = (state == RF_DATA) && RVALID && (beat == LAST_WORD);

   // Every channel uses valid/ready: a transfer happens on a rising edge where
   // both are high; a raised VALID and its payload hold until READY, and no
   // VALID is ever derived combinationally from the matching READY.
   assign RECEIVE_READY = (state == IDLE) && !RST;
   assign dbg_state     = state;

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = {req_index, req_off};
      mem_wdata = req_data;
      if (!RST) begin
         if (state == LOOKUP && hit && req_write) begin
            mem_we = 1'b1;
         end else if (state == RF_DATA && RVALID && RREADY) begin
            mem_we    = 1'b1;
            mem_waddr = {req_index, beat};
            mem_wdata = RDATA;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (mem_we) data_mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge CLK) begin
      if (!RST && refill_done) tag_mem[req_index] <= req_tag;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         line_valid <= '0;
         line_dirty <= '0;
         req_word   <= '0;
         req_data   <= '0;
         req_write  <= 1'b0;
         beat       <= '0;
         SEND_VALID <= 1'b0;
         SEND_DATA  <= '0;
         ARVALID    <= 1'b0;
         ARADDR     <= '0;
         RREADY     <= 1'b0;
         AWVALID    <= 1'b0;
         AWADDR     <= '0;
         WVALID     <= 1'b0;
         WDATA      <= '0;
         WLAST      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (RECEIVE_ADDR_VALID) begin
                  req_word  <= RECEIVE_ADDR[31:2];
                  req_data  <= RECEIVE_DATA;
                  req_write <= RECEIVE_DATA_VALID;
                  state     <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  if (req_write) begin
                     line_dirty[req_index] <= 1'b1;
                     SEND_DATA             <= req_data;
                  end else begin
                     SEND_DATA <= data_mem[{req_index, req_off}];
                  end
                  SEND_VALID <= 1'b1;
                  state      <= RESP;
               end else begin
                  beat <= '0;
                  if (line_valid[req_index] && line_dirty[req_index]) begin
                     AWVALID <= 1'b1;
                     AWADDR  <= {tag_mem[req_index], req_index, {(OFF_W+2){1'b0}}};
                     state   <= WB_ADDR;
                  end else begin
                     ARVALID <= 1'b1;
                     ARADDR  <= {req_tag, req_index, {(OFF_W+2){1'b0}}};
                     state   <= RF_ADDR;
                  end
               end
            end
            WB_ADDR: begin
               if (AWREADY) begin
                  AWVALID <= 1'b0;
                  WVALID  <= 1'b1;
                  WDATA   <= data_mem[{req_index, beat}];
                  WLAST   <= (beat == LAST_WORD);
                  state   <= WB_DATA;
               end
            end
            WB_DATA: begin
               if (WREADY) begin
                  if (beat == LAST_WORD) begin
                     WVALID  <= 1'b0;
                     WLAST   <= 1'b0;
                     beat    <= '0;
                     ARVALID <= 1'b1;
                     ARADDR  <= {req_tag, req_index, {(OFF_W+2){1'b0}}};
                     state   <= RF_ADDR;
                  end else begin
                     beat  <= beat_nxt;
                     WDATA <= data_mem[{req_index, beat_nxt}];
                     WLAST <= (beat_nxt == LAST_WORD);
                  end
               end
            end
            RF_ADDR: begin
               if (ARREADY) begin
                  ARVALID <= 1'b0;
                  RREADY  <= 1'b1;
                  state   <= RF_DATA;
               end
            end
            RF_DATA: begin
               // After the final beat the line is clean; LOOKUP then hits and finishes the request.
               if (RVALID) begin
                  if (beat == LAST_WORD) begin
                     RREADY                <= 1'b0;
                     beat                  <= '0;
                     line_valid[req_index] <= 1'b1;
                     line_dirty[req_index] <= 1'b0;
                     state                 <= LOOKUP;
                  end else begin
                     beat <= beat_nxt;
                  end
               end
            end
            RESP: begin
               if (SEND_READY) begin
                  SEND_VALID <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_cache.sv
// Directed bench for mem_cache with an AXI slave model that inserts random waits.
module tb_mem_cache;
   localparam int LINE_WORDS  = 8;
   localparam int INDEX_WIDTH = 6;
   localparam logic [31:0] SET_STRIDE = 32'(LINE_WORDS * 4) << INDEX_WIDTH;

   logic        CLK;
   logic        RST;
   logic        RECEIVE_ADDR_VALID;
   logic [31:0] RECEIVE_ADDR;
   logic        RECEIVE_DATA_VALID;
   logic [31:0] RECEIVE_DATA;
   logic        RECEIVE_READY;
   logic        SEND_VALID;
   logic [31:0] SEND_DATA;
   logic        SEND_READY;
   logic [31:0] ARADDR;
   logic        ARVALID;
   logic        ARREADY;
   logic        RVALID;
   logic [31:0] RDATA;
   logic        RREADY;
   logic [31:0] AWADDR;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic        WVALID;
   logic        WLAST;
   logic        WREADY;
   logic [2:0]  dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   int ar_count = 0;
   int aw_count = 0;
   int r_beats  = 0;
   int w_beats  = 0;
   int wlast_err = 0;
   int w_at_ar  = 0;
   logic [31:0] last_araddr = '0;
   logic [31:0] last_awaddr = '0;
   logic [31:0] wb_data [LINE_WORDS];
   logic [31:0] axi_mem [logic [31:0]];

   mem_cache #(.LINE_WORDS(LINE_WORDS), .INDEX_WIDTH(INDEX_WIDTH)) dut (
      .CLK(CLK), .RST(RST),
      .RECEIVE_ADDR_VALID(RECEIVE_ADDR_VALID), .RECEIVE_ADDR(RECEIVE_ADDR),
      .RECEIVE_DATA_VALID(RECEIVE_DATA_VALID), .RECEIVE_DATA(RECEIVE_DATA),
      .RECEIVE_READY(RECEIVE_READY),
      .SEND_VALID(SEND_VALID), .SEND_DATA(SEND_DATA), .SEND_READY(SEND_READY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RVALID(RVALID), .RDATA(RDATA), .RREADY(RREADY),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #900000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   // Untouched memory reads back a pattern derived from its address.
   function automatic logic [31:0] mem_rd(input logic [31:0] addr);
      if (axi_mem.exists(addr)) return axi_mem[addr];
      return 32'hC0DE_0000 ^ addr;
   endfunction

   // ---------------- AXI slave: AR / R ----------------
   initial begin : bfm_read
      logic [31:0] base;
      int guard;
      ARREADY = 1'b0;
      RVALID  = 1'b0;
      RDATA   = '0;
      forever begin
         @(negedge CLK);
         if (ARVALID && !RST) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            ARREADY     = 1'b1;
            base        = ARADDR;
            last_araddr = ARADDR;
            w_at_ar     = w_beats;
            ar_count++;
            @(negedge CLK);
            ARREADY = 1'b0;
            for (int k = 0; k < LINE_WORDS; k++) begin
               repeat ($urandom_range(0, 3)) @(negedge CLK);
               RVALID = 1'b1;
               RDATA  = mem_rd(base + 32'(4 * k));
               guard  = 0;
               while (!RREADY && guard < 50) begin
                  @(negedge CLK);
                  guard++;
               end
               @(negedge CLK);
               r_beats++;
               RVALID = 1'b0;
            end
         end
      end
   end

   // ---------------- AXI slave: AW / W ----------------
   initial begin : bfm_write
      logic [31:0] base;
      int guard;
      AWREADY = 1'b0;
      WREADY  = 1'b0;
      forever begin
         @(negedge CLK);
         if (AWVALID && !RST) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            AWREADY     = 1'b1;
            base        = AWADDR;
            last_awaddr = AWADDR;
            aw_count++;
            @(negedge CLK);
            AWREADY = 1'b0;
            for (int k = 0; k < LINE_WORDS; k++) begin
               repeat ($urandom_range(0, 2)) @(negedge CLK);
               guard = 0;
               while (!WVALID && guard < 50) begin
                  @(negedge CLK);
                  guard++;
               end
               WREADY     = 1'b1;
               wb_data[k] = WDATA;
               axi_mem[base + 32'(4 * k)] = WDATA;
               if (WLAST !== (k == LINE_WORDS - 1)) wlast_err++;
               w_beats++;
               @(negedge CLK);
               WREADY = 1'b0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      RST = 1'b1;
      RECEIVE_ADDR_VALID = 1'b0;
      RECEIVE_DATA_VALID = 1'b0;
      SEND_READY = 1'b0;
      repeat (10) @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic send_req(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
      int guard;
      @(negedge CLK);
      RECEIVE_ADDR_VALID = 1'b1;
      RECEIVE_ADDR       = addr;
      RECEIVE_DATA_VALID = wr;
      RECEIVE_DATA       = wd;
      guard = 0;
      while (!RECEIVE_READY && guard < 200) begin
         @(negedge CLK);
         guard++;
      end
      @(negedge CLK);
      RECEIVE_ADDR_VALID = 1'b0;
      RECEIVE_DATA_VALID = 1'b0;
   endtask

   // lat counts negedges since the accepting edge; a hit yields 2.
   task automatic wait_resp(output logic [31:0] rd, output int lat);
      lat = 1;
      while (!SEND_VALID && lat < 500) begin
         @(negedge CLK);
         lat++;
      end
      if (!SEND_VALID) begin
         n_checks++;
         $display("FAIL resp_timeout SEND_VALID=%b after %0d cycles, required 1", SEND_VALID, lat);
      end
      rd = SEND_DATA;
   endtask

   task automatic ack_resp();
      SEND_READY = 1'b1;
      @(negedge CLK);
      SEND_READY = 1'b0;
   endtask

   task automatic do_req(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         output logic [31:0] rd, output int lat);
      send_req(addr, wr, wd);
      wait_resp(rd, lat);
      ack_resp();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RST = 1'b1;
      RECEIVE_ADDR_VALID = 1'b0;
      RECEIVE_DATA_VALID = 1'b0;
      RECEIVE_ADDR = '0;
      RECEIVE_DATA = '0;
      SEND_READY = 1'b0;
      repeat (10) @(negedge CLK);
      n_checks++;
      if (RECEIVE_READY !== 1'b0) $display("FAIL reset_ready_low got=%b exp=0", RECEIVE_READY);
      else n_pass++;
      n_checks++;
      if ({SEND_VALID, ARVALID, AWVALID, WVALID, RREADY, WLAST} !== 6'b0)
         $display("FAIL reset_outputs got=%b exp=000000", {SEND_VALID, ARVALID, AWVALID, WVALID, RREADY, WLAST});
      else n_pass++;
      n_checks++;
      if (dbg_state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", dbg_state);
      else n_pass++;
      RST = 1'b0;
      #1;
      n_checks++;
      if (RECEIVE_READY !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", RECEIVE_READY);
      else n_pass++;
   endtask

   task automatic test_read_after_write();
      logic [31:0] rd;
      int lat;
      int ar0;
      do_reset();
      ar0 = ar_count;
      do_req(32'h0000_1000, 1'b1, 32'h1234_5678, rd, lat);
      n_checks++;
      if (rd !== 32'h1234_5678) $display("FAIL raw_write_echo got=%h exp=12345678", rd);
      else n_pass++;
      do_req(32'h0000_1000, 1'b0, 32'h0, rd, lat);
      n_checks++;
      if (rd !== 32'h1234_5678) $display("FAIL raw_read got=%h exp=12345678", rd);
      else n_pass++;
      n_checks++;
      if (lat !== 2) $display("FAIL hit_latency got=%0d exp=2", lat);
      else n_pass++;
      n_checks++;
      if (ar_count - ar0 !== 1) $display("FAIL raw_ar_bursts got=%0d exp=1", ar_count - ar0);
      else n_pass++;
   endtask

   task automatic test_miss_refill();
      logic [31:0] rd;
      int lat;
      int ar0, r0, aw0;
      do_reset();
      ar0 = ar_count;
      r0  = r_beats;
      aw0 = aw_count;
      do_req(32'h0000_2004, 1'b0, 32'h0, rd, lat);
      n_checks++;
      if (rd !== 32'hC0DE_2004) $display("FAIL refill_data got=%h exp=c0de2004", rd);
      else n_pass++;
      n_checks++;
      if (ar_count - ar0 !== 1) $display("FAIL refill_ar_count got=%0d exp=1", ar_count - ar0);
      else n_pass++;
      n_checks++;
      if (last_araddr !== 32'h0000_2000) $display("FAIL refill_araddr got=%h exp=00002000", last_araddr);
      else n_pass++;
      n_checks++;
      if (r_beats - r0 !== 8) $display("FAIL refill_r_beats got=%0d exp=8", r_beats - r0);
      else n_pass++;
      n_checks++;
      if (aw_count - aw0 !== 0) $display("FAIL refill_no_wb got=%0d exp=0", aw_count - aw0);
      else n_pass++;
      do_req(32'h0000_201C, 1'b0, 32'h0, rd, lat);
      n_checks++;
      if (rd !== 32'hC0DE_201C) $display("FAIL refill_last_word got=%h exp=c0de201c", rd);
      else n_pass++;
      n_checks++;
      if (lat !== 2 || ar_count - ar0 !== 1)
         $display("FAIL refill_line_hit lat=%0d ar=%0d exp lat=2 ar=1", lat, ar_count - ar0);
      else n_pass++;
   endtask

   task automatic test_dirty_evict();
      logic [31:0] rd;
      int lat;
      int aw0, w0, wl0;
      do_reset();
      do_req(32'h0000_0000, 1'b1, 32'hA5A5_5A5A, rd, lat);
      n_checks++;
      if (rd !== 32'hA5A5_5A5A) $display("FAIL evict_write_echo got=%h exp=a5a55a5a", rd);
      else n_pass++;
      aw0 = aw_count;
      w0  = w_beats;
      wl0 = wlast_err;
      do_req(SET_STRIDE, 1'b0, 32'h0, rd, lat);
      n_checks++;
      if (rd !== (32'hC0DE_0000 ^ SET_STRIDE)) $display("FAIL evict_read got=%h exp=%h", rd, 32'hC0DE_0000 ^ SET_STRIDE);
      else n_pass++;
      n_checks++;
      if (aw_count - aw0 !== 1) $display("FAIL evict_aw_count got=%0d exp=1", aw_count - aw0);
      else n_pass++;
      n_checks++;
      if (last_awaddr !== 32'h0000_0000) $display("FAIL evict_awaddr got=%h exp=00000000", last_awaddr);
      else n_pass++;
      n_checks++;
      if (w_beats - w0 !== 8) $display("FAIL evict_w_beats got=%0d exp=8", w_beats - w0);
      else n_pass++;
      n_checks++;
      if (wlast_err - wl0 !== 0) $display("FAIL evict_wlast bad_beats=%0d exp=0", wlast_err - wl0);
      else n_pass++;
      n_checks++;
      if (wb_data[0] !== 32'hA5A5_5A5A) $display("FAIL evict_wdata0 got=%h exp=a5a55a5a", wb_data[0]);
      else n_pass++;
      n_checks++;
      if (wb_data[5] !== 32'hC0DE_0014) $display("FAIL evict_wdata5 got=%h exp=c0de0014", wb_data[5]);
      else n_pass++;
      n_checks++;
      if (w_at_ar - w0 !== 8) $display("FAIL evict_ar_after_w w_beats_at_ar=%0d exp=8", w_at_ar - w0);
      else n_pass++;
      n_checks++;
      if (last_araddr !== SET_STRIDE) $display("FAIL evict_araddr got=%h exp=%h", last_araddr, SET_STRIDE);
      else n_pass++;
      do_req(32'h0000_0000, 1'b0, 32'h0, rd, lat);
      n_checks++;
      if (rd !== 32'hA5A5_5A5A) $display("FAIL evict_reread got=%h exp=a5a55a5a", rd);
      else n_pass++;
      n_checks++;
      if (aw_count - aw0 !== 1) $display("FAIL evict_clean_victim aw=%0d exp=1", aw_count - aw0);
      else n_pass++;
   endtask

   task automatic test_handshake();
      logic [31:0] rd;
      int lat;
      int bad_valid, bad_data, bad_ready;
      bad_valid = 0;
      bad_data  = 0;
      bad_ready = 0;
      send_req(32'h0000_0000, 1'b0, 32'h0);
      wait_resp(rd, lat);
      n_checks++;
      if (rd !== 32'hA5A5_5A5A) $display("FAIL hs_data got=%h exp=a5a55a5a", rd);
      else n_pass++;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (SEND_VALID !== 1'b1) bad_valid++;
         if (SEND_DATA !== 32'hA5A5_5A5A) bad_data++;
         if (RECEIVE_READY !== 1'b0) bad_ready++;
      end
      n_checks++;
      if (bad_valid !== 0) $display("FAIL hs_valid_held dropped_cycles=%0d exp=0", bad_valid);
      else n_pass++;
      n_checks++;
      if (bad_data !== 0) $display("FAIL hs_data_held changed_cycles=%0d exp=0", bad_data);
      else n_pass++;
      n_checks++;
      if (bad_ready !== 0) $display("FAIL hs_no_accept ready_cycles=%0d exp=0", bad_ready);
      else n_pass++;
      ack_resp();
      n_checks++;
      if ({SEND_VALID, RECEIVE_READY} !== 2'b01)
         $display("FAIL hs_release got valid,ready=%b exp=01", {SEND_VALID, RECEIVE_READY});
      else n_pass++;
   endtask

   task automatic test_reset_invalidate();
      logic [31:0] rd;
      int lat;
      int ar0;
      do_req(32'h0000_3000, 1'b1, 32'hDEAD_BEEF, rd, lat);
      do_reset();
      ar0 = ar_count;
      do_req(32'h0000_3000, 1'b0, 32'h0, rd, lat);
      n_checks++;
      if (rd !== 32'hC0DE_3000) $display("FAIL inval_read got=%h exp=c0de3000", rd);
      else n_pass++;
      n_checks++;
      if (ar_count - ar0 !== 1) $display("FAIL inval_refetch got=%0d exp=1", ar_count - ar0);
      else n_pass++;
   endtask

   task automatic test_soak();
      logic [31:0] rd, addr, data;
      int lat;
      for (int i = 0; i < 100; i++) begin
         addr = $urandom() & 32'hFFFF_FFFC;
         data = $urandom();
         do_req(addr, 1'b1, data, rd, lat);
         n_checks++;
         if (rd !== data) $display("FAIL soak_echo[%0d] addr=%h got=%h exp=%h", i, addr, rd, data);
         else n_pass++;
         do_req(addr, 1'b0, 32'h0, rd, lat);
         n_checks++;
         if (rd !== data) $display("FAIL soak_read[%0d] addr=%h got=%h exp=%h", i, addr, rd, data);
         else n_pass++;
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_read_after_write();
      test_miss_refill();
      test_dirty_evict();
      test_handshake();
      test_reset_invalidate();
      test_soak();
      repeat (5) @(negedge CLK);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
